// File: rtl/i2c_target.sv
// I2C target with a 256 x 8 register file and an auto-incrementing pointer.
// The 7-bit address is {1, straps}; the block is open-drain on SDA and never stretches SCL.
module i2c_target (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic address5_i,
    input  logic address4_i,
    input  logic address3_i,
    input  logic address2_i,
    input  logic address1_i,
    input  logic address0_i,
    input  logic scl_i,
    inout  wire  sda_io
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_REG       = 4'd3;
    localparam logic [3:0] ST_REG_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;
    localparam logic [3:0] ST_IGNORE    = 4'd9;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic [3:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] ptr_q, ptr_d;
    logic       oe_q, oe_d;
    logic       rw_q, rw_d;
    logic       we;
    logic [7:0] regs_q [256];

    logic       scl, sda, scl_rise, scl_fall, start_det, stop_det;
    logic [6:0] dev_addr;
    logic [7:0] byte_in;
    logic [7:0] ptr_inc;

    assign scl       = scl_sync_q[1];
    assign sda       = sda_sync_q[1];
    assign scl_rise  = scl & ~scl_prev_q;
    assign scl_fall  = ~scl & scl_prev_q;
    assign start_det = scl & scl_prev_q & sda_prev_q & ~sda;
    assign stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;
    assign dev_addr  = {1'b1, address5_i, address4_i, address3_i, address2_i, address1_i, address0_i};
    assign byte_in   = {sr_q[6:0], sda};
    assign ptr_inc   = ptr_q + 8'd1;

    assign sda_io = oe_q ? 1'b0 : 1'bz;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        ptr_d   = ptr_q;
        oe_d    = oe_q;
        rw_d    = rw_q;
        we      = 1'b0;
        if (start_det) begin
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: if (scl_rise) begin
                    sr_d  = byte_in;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        rw_d    = sda;
                        cnt_d   = 4'd0;
                        state_d = (sr_q[6:0] == dev_addr) ? ST_ADDR_ACK : ST_IGNORE;
                    end
                end
                // ACK states: first SCL fall pulls SDA low, second one releases it and moves on
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else if (rw_q) begin
                        sr_d    = regs_q[ptr_q];
                        oe_d    = ~regs_q[ptr_q][7];
                        cnt_d   = 4'd0;
                        state_d = ST_RDATA;
                    end else begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = ST_REG;
                    end
                end
                ST_REG: if (scl_rise) begin
                    sr_d  = byte_in;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        ptr_d   = byte_in;
                        cnt_d   = 4'd0;
                        state_d = ST_REG_ACK;
                    end
                end
                ST_REG_ACK, ST_WDATA_ACK: if (scl_fall) begin
                    oe_d = ~oe_q;
                    if (oe_q) begin
                        state_d = ST_WDATA;
                    end
                end
                ST_WDATA: if (scl_rise) begin
                    sr_d  = byte_in;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        we      = 1'b1;
                        ptr_d   = ptr_inc;
                        cnt_d   = 4'd0;
                        state_d = ST_WDATA_ACK;
                    end
                end
                // cnt counts SCL rises of the byte; cnt==0 on a fall means a freshly reloaded byte
                ST_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd0) begin
                            oe_d = ~sr_q[7];
                        end else if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = ST_RDATA_ACK;
                        end else begin
                            oe_d = ~sr_q[6];
                            sr_d = {sr_q[6:0], 1'b0};
                        end
                    end
                end
                ST_RDATA_ACK: if (scl_rise) begin
                    if (!sda) begin
                        ptr_d   = ptr_inc;
                        sr_d    = regs_q[ptr_inc];
                        cnt_d   = 4'd0;
                        state_d = ST_RDATA;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            sr_q       <= 8'h00;
            ptr_q      <= 8'h00;
            oe_q       <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_io};
            scl_prev_q <= scl;
            sda_prev_q <= sda;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            rw_q       <= rw_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 256; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (we) begin
            regs_q[ptr_q] <= byte_in;
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C controller issues directed transactions,
// expected ACK bits and read bytes go to a scoreboard that a monitor drains.
module tb_i2c_target;

    localparam int Q = 4;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic scl = 1'b1;
    logic sda_drv = 1'b1;
    wire  sda_bus;

    assign sda_bus = sda_drv ? 1'bz : 1'b0;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_target dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .address5_i (1'b0),
        .address4_i (1'b0),
        .address3_i (1'b0),
        .address2_i (1'b0),
        .address1_i (1'b0),
        .address0_i (1'b1),
        .scl_i      (scl),
        .sda_io     (sda_bus)
    );

    logic [7:0] exp_q [$];
    string      name_q [$];
    logic [7:0] obs_q [$];
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic push_exp(input string n, input logic [7:0] v);
        name_q.push_back(n);
        exp_q.push_back(v);
    endtask

    task automatic push_obs(input logic [7:0] v);
        obs_q.push_back(v);
    endtask

    // Scoreboard monitor
    initial begin
        logic [7:0] o, e;
        string nm;
        forever begin
            @(posedge clk);
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_obs: got %02h, required nothing", o);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (o !== e) begin
                        n_fail++;
                        $display("FAIL %s: got %02h, required %02h", nm, o, e);
                    end
                end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wq();
        scl = 1'b1;     wq();
        sda_drv = 1'b0; wq();
        scl = 1'b0;     wq();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wq();
        scl = 1'b1;     wq();
        sda_drv = 1'b1; wq();
    endtask

    task automatic wbit(input logic b);
        sda_drv = b; wq();
        scl = 1'b1;  wq();
        wq();
        scl = 1'b0;  wq();
    endtask

    task automatic rbit(output logic b);
        sda_drv = 1'b1; wq();
        scl = 1'b1;     wq();
        b = sda_bus;    wq();
        scl = 1'b0;     wq();
    endtask

    task automatic wr(input string n, input logic [7:0] d, input logic exp_ack);
        logic a;
        push_exp(n, {7'd0, exp_ack});
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(a);
        push_obs({7'd0, a});
    endtask

    task automatic rd(input string n, input logic [7:0] exp_d, input logic ack);
        logic [7:0] d;
        logic b;
        push_exp(n, exp_d);
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(ack);
        push_obs(d);
    endtask

    // Set pointer, repeated START, read one byte, NACK, STOP
    task automatic read1(input string n, input logic [7:0] r, input logic [7:0] exp_d);
        i2c_start();
        wr({n, "_a"}, 8'h82, 1'b0);
        wr({n, "_r"}, r, 1'b0);
        i2c_start();
        wr({n, "_ra"}, 8'h83, 1'b0);
        rd(n, exp_d, 1'b1);
        i2c_stop();
    endtask

    initial begin
        logic b;
        repeat (5) @(negedge clk);
        push_exp("reset_sda", 8'h01);
        push_obs({7'd0, sda_bus});
        rst_ni = 1'b1;
        repeat (5) @(negedge clk);

        // Wrong address 0x48: no ACK, then a read attempt
        i2c_start();
        wr("a48_addr", 8'h90, 1'b1);
        wr("a48_reg", 8'hBE, 1'b1);
        i2c_stop();
        i2c_start();
        wr("a48_rd", 8'h91, 1'b1);
        i2c_stop();
        read1("a48_regBE", 8'hBE, 8'h00);

        // Wrong address 0x37
        i2c_start();
        wr("a37_addr", 8'h6E, 1'b1);
        wr("a37_reg", 8'hDE, 1'b1);
        wr("a37_data", 8'h4D, 1'b1);
        i2c_stop();
        read1("a37_regDE", 8'hDE, 8'h00);

        // Write and read back through repeated START
        i2c_start();
        wr("w41_addr", 8'h82, 1'b0);
        wr("w41_reg", 8'hDE, 1'b0);
        wr("w41_data", 8'h4D, 1'b0);
        i2c_stop();
        read1("rd_DE", 8'hDE, 8'h4D);

        // Burst write with pointer wrap, then burst read across the wrap
        i2c_start();
        wr("bw_addr", 8'h82, 1'b0);
        wr("bw_reg", 8'hFE, 1'b0);
        wr("bw_d0", 8'h11, 1'b0);
        wr("bw_d1", 8'h22, 1'b0);
        wr("bw_d2", 8'h33, 1'b0);
        i2c_stop();
        i2c_start();
        wr("br_addr", 8'h82, 1'b0);
        wr("br_reg", 8'hFE, 1'b0);
        i2c_start();
        wr("br_rd", 8'h83, 1'b0);
        rd("br_FE", 8'h11, 1'b0);
        rd("br_FF", 8'h22, 1'b0);
        rd("br_00", 8'h33, 1'b1);
        i2c_stop();

        // STOP after 4 data bits leaves the register untouched
        i2c_start();
        wr("p_addr", 8'h82, 1'b0);
        wr("p_reg", 8'h10, 1'b0);
        wr("p_data", 8'hA5, 1'b0);
        i2c_stop();
        i2c_start();
        wr("p2_addr", 8'h82, 1'b0);
        wr("p2_reg", 8'h10, 1'b0);
        wbit(1'b0); wbit(1'b0); wbit(1'b1); wbit(1'b1);
        i2c_stop();
        read1("partial_10", 8'h10, 8'hA5);

        // Reset while the target drives bit 7 (0) of regs[0xFE]=0x11
        i2c_start();
        wr("rs_addr", 8'h82, 1'b0);
        wr("rs_reg", 8'hFE, 1'b0);
        i2c_start();
        wr("rs_rd", 8'h83, 1'b0);
        sda_drv = 1'b1; wq();
        scl = 1'b1;     wq();
        push_exp("rd_bit7_driven", 8'h00);
        push_obs({7'd0, sda_bus});
        rst_ni = 1'b0;
        #1;
        push_exp("rst_release", 8'h01);
        b = sda_bus;
        push_obs({7'd0, b});
        wq();
        scl = 1'b0; wq();
        rst_ni = 1'b1;
        wq();
        scl = 1'b1; wq();
        wq();

        // Every register reads back 0x00 after reset
        i2c_start();
        wr("z_addr", 8'h82, 1'b0);
        wr("z_reg", 8'h00, 1'b0);
        i2c_start();
        wr("z_rd", 8'h83, 1'b0);
        for (int i = 0; i < 256; i++) begin
            rd($sformatf("zero_%02h", i), 8'h00, (i == 255) ? 1'b1 : 1'b0);
        end
        i2c_stop();

        repeat (20) @(negedge clk);
        while (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no response, required %02h", name_q.pop_front(), exp_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
